// File: rtl/game_round_controller.sv
// Round sequencer for the multimode counter game: loads each round, forwards the
// player's mode, tallies WINNER/LOSER outcomes and declares the game result.
module game_round_controller #(
  parameter int WIDTH         = 4,
  parameter int WINS_TO_END   = 3,
  parameter int LOSSES_TO_END = 3,
  parameter int ROUND_TIMEOUT = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [WIDTH-1:0]                     seed,
  input  logic [1:0]                           mode_sel,
  input  logic                                 winner,
  input  logic                                 loser,
  output logic [1:0]                           ctrl_value,
  output logic [WIDTH-1:0]                     init_value,
  output logic                                 init,
  output logic [$clog2(WINS_TO_END+1)-1:0]     win_count,
  output logic [$clog2(LOSSES_TO_END+1)-1:0]   lose_count,
  output logic [7:0]                           round_num,
  output logic                                 busy,
  output logic                                 game_over,
  output logic                                 player_won
);

  localparam int WC_W  = $clog2(WINS_TO_END + 1);
  localparam int LC_W  = $clog2(LOSSES_TO_END + 1);
  localparam int TMO_W = $clog2(ROUND_TIMEOUT);
  localparam int EXT_W = (WIDTH > 8) ? WIDTH : 8;

  localparam logic [WC_W-1:0]  WIN_MAX  = WC_W'(WINS_TO_END);
  localparam logic [LC_W-1:0]  LOSE_MAX = LC_W'(LOSSES_TO_END);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ROUND_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_PLAY,
    S_ROUND_END,
    S_GAME_OVER
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WC_W-1:0]  win_q, win_d;
  logic [LC_W-1:0]  lose_q, lose_d;
  logic [7:0]       round_q, round_d;
  logic             won_q, won_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] ival_q, ival_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic [7:0]       round_m1;
  logic [EXT_W-1:0] round_ext;
  logic [WIDTH-1:0] load_val;

  // Each round starts one count higher than the last, wrapping at the data width.
  always_comb begin
    round_m1  = round_q - 8'd1;
    round_ext = EXT_W'(round_m1);
    load_val  = seed_q + round_ext[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      seed_q  <= '0;
      win_q   <= '0;
      lose_q  <= '0;
      round_q <= '0;
      won_q   <= 1'b0;
      ctrl_q  <= '0;
      ival_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
      round_q <= round_d;
      won_q   <= won_d;
      ctrl_q  <= ctrl_d;
      ival_q  <= ival_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    win_d   = win_q;
    lose_d  = lose_q;
    round_d = round_q;
    won_d   = won_q;
    ctrl_d  = ctrl_q;
    ival_d  = ival_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (start) begin
          state_d = S_LOAD;
          seed_d  = seed;
          win_d   = '0;
          lose_d  = '0;
          round_d = 8'd1;
          won_d   = 1'b0;
        end
      end
      S_LOAD: begin
        state_d = S_SETTLE;
        tmo_d   = '0;
        ival_d  = load_val;
      end
      S_SETTLE: begin
        // Flags are deliberately not looked at here; they may be left over from the last round.
        state_d = S_PLAY;
        ctrl_d  = mode_sel;
      end
      S_PLAY: begin
        ctrl_d = mode_sel;
        tmo_d  = tmo_q + 1'b1;
        if (winner) begin
          state_d = S_ROUND_END;
          if (win_q != WIN_MAX) win_d = win_q + 1'b1;
        end else if (loser || (tmo_q == TMO_LAST)) begin
          state_d = S_ROUND_END;
          if (lose_q != LOSE_MAX) lose_d = lose_q + 1'b1;
        end
      end
      S_ROUND_END: begin
        if (win_q == WIN_MAX) begin
          state_d = S_GAME_OVER;
          won_d   = 1'b1;
        end else if (lose_q == LOSE_MAX) begin
          state_d = S_GAME_OVER;
          won_d   = 1'b0;
        end else begin
          state_d = S_LOAD;
          round_d = round_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    init       = (state_q == S_LOAD);
    init_value = (state_q == S_LOAD) ? load_val : ival_q;
    ctrl_value = ((state_q == S_PLAY) || (state_q == S_ROUND_END)) ? ctrl_q : 2'd0;
    win_count  = win_q;
    lose_count = lose_q;
    round_num  = round_q;
    busy       = (state_q == S_LOAD) || (state_q == S_SETTLE) ||
                 (state_q == S_PLAY) || (state_q == S_ROUND_END);
    game_over  = (state_q == S_GAME_OVER);
    player_won = won_q;
  end

endmodule

// File: tb/tb_game_round_controller.sv
// Directed bench for game_round_controller; expected init values are queued when a
// game is started and popped as each init pulse appears.
`timescale 1ns/100ps
module tb_game_round_controller;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] seed;
  logic [1:0] mode_sel;
  logic       winner;
  logic       loser;
  logic [1:0] ctrl_value;
  logic [3:0] init_value;
  logic       init;
  logic [1:0] win_count;
  logic [1:0] lose_count;
  logic [7:0] round_num;
  logic       busy;
  logic       game_over;
  logic       player_won;

  int total = 0;
  int bad   = 0;
  logic [3:0] sb_q[$];

  game_round_controller #(
    .WIDTH(4), .WINS_TO_END(3), .LOSSES_TO_END(3), .ROUND_TIMEOUT(32)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .mode_sel(mode_sel),
    .winner(winner), .loser(loser), .ctrl_value(ctrl_value), .init_value(init_value),
    .init(init), .win_count(win_count), .lose_count(lose_count), .round_num(round_num),
    .busy(busy), .game_over(game_over), .player_won(player_won)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for an init pulse, then compares its value with the queue head.
  task automatic sb_init(input string tag);
    int n;
    logic [3:0] exp;
    n = 0;
    while (init !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_pulse"}, init, 1);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 4'bx;
    chk({tag, "_value"}, init_value, exp);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 0; seed = 0; mode_sel = 0; winner = 0; loser = 0;
    #2 rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_round", round_num, 0);
    chk("rst_init", init, 0);
    chk("rst_gameover", game_over, 0);
    tick(); tick();
    @(negedge clk) rst = 1'b1;
    tick();

    // Game 1: three straight wins from seed 10
    seed = 4'd10; start = 1;
    sb_q.push_back(4'd10); sb_q.push_back(4'd11); sb_q.push_back(4'd12);
    tick();
    start = 0;
    chk("g1_start_latency", init, 1);
    chk("g1_round1", round_num, 1);
    for (int r = 1; r <= 3; r++) begin
      sb_init("g1_init");
      chk("g1_round", round_num, r);
      tick();
      chk("g1_settle_init", init, 0);
      tick();
      winner = 1;
      tick();
      winner = 0;
      chk("g1_wins", win_count, r);
      tick();
    end
    chk("g1_gameover", game_over, 1);
    chk("g1_won", player_won, 1);
    chk("g1_final_round", round_num, 3);
    chk("g1_busy", busy, 0);

    // Game 2: restart from GAME_OVER, loss by flag, by timeout, by flag
    seed = 4'd2; start = 1;
    sb_q.push_back(4'd2); sb_q.push_back(4'd3); sb_q.push_back(4'd4);
    tick();
    start = 0;
    chk("g2_gameover_clr", game_over, 0);
    chk("g2_won_clr", player_won, 0);
    chk("g2_wins_clr", win_count, 0);
    chk("g2_round1", round_num, 1);
    sb_init("g2_r1");
    tick(); tick();
    loser = 1;
    tick();
    loser = 0;
    chk("g2_loss1", lose_count, 1);
    tick();
    sb_init("g2_r2");
    tick(); tick();
    start = 1;
    n = 0;
    while (lose_count != 2'd2 && n < 100) begin
      tick();
      start = 0;
      n++;
    end
    chk("g2_timeout_cycles", n, 32);
    chk("g2_start_ignored", round_num, 2);
    tick();
    sb_init("g2_r3");
    tick(); tick();
    loser = 1;
    tick();
    loser = 0;
    tick();
    chk("g2_losses", lose_count, 3);
    chk("g2_gameover", game_over, 1);
    chk("g2_won", player_won, 0);

    // Game 3: stale and simultaneous flags, wrap, mode passthrough
    seed = 4'd15; start = 1;
    sb_q.push_back(4'd15); sb_q.push_back(4'd0); sb_q.push_back(4'd1);
    tick();
    start = 0;
    sb_init("g3_r1");
    winner = 1; loser = 1;
    tick();
    chk("g3_settle_ignored", win_count, 0);
    tick();
    chk("g3_play_entry_nowin", win_count, 0);
    tick();
    winner = 0; loser = 0;
    chk("g3_both_win", win_count, 1);
    chk("g3_both_noloss", lose_count, 0);
    tick();
    sb_init("g3_wrap");
    tick();
    mode_sel = 0;
    tick();
    chk("g3_ctrl_entry", ctrl_value, 0);
    for (int m = 1; m <= 3; m++) begin
      mode_sel = 2'(m);
      #1;
      chk("g3_ctrl_delay", ctrl_value, m - 1);
      tick();
      chk("g3_ctrl_follow", ctrl_value, m);
    end
    loser = 1;
    tick();
    loser = 0;
    chk("g3_loss", lose_count, 1);
    chk("g3_ctrl_held", ctrl_value, 3);
    tick();
    chk("g3_ctrl_load", ctrl_value, 0);
    sb_init("g3_r3");
    tick(); tick(); tick();

    // Reset in the middle of PLAY
    #2 rst = 1'b0;
    #0.5;
    chk("mrst_busy", busy, 0);
    chk("mrst_round", round_num, 0);
    chk("mrst_wins", win_count, 0);
    chk("mrst_ctrl", ctrl_value, 0);
    chk("mrst_ival", init_value, 0);
    #0.5 rst = 1'b1;
    tick();
    chk("mrst_no_init", init, 0);
    chk("mrst_idle", busy, 0);
    seed = 4'd5; start = 1;
    sb_q.push_back(4'd5);
    tick();
    start = 0;
    chk("mrst_round1", round_num, 1);
    sb_init("mrst_init");
    chk("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_round_controller.md
Name: game_round_controller

Overview:
- Sequences the multimode counter through a multi-round game.
- Each round: loads the counter's initial value with a one-cycle init pulse, passes the player's mode selection through as the counter control value, and waits for the counter's WINNER/LOSER flags or a timeout.
- Tallies wins and losses; declares game over when either tally reaches its threshold.
- Sits between the player-input logic and the multimode counter instance.

Parameters:
- WIDTH, 4, counter data width (width of init_value and seed).
- WINS_TO_END, 3, wins needed to end the game with a player victory.
- LOSSES_TO_END, 3, losses needed to end the game with a player defeat.
- ROUND_TIMEOUT, 32, maximum PLAY cycles per round before a forced loss (≥2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  begin a new game; sampled in IDLE and GAME_OVER only.
- seed  input  WIDTH  base initial counter value; captured when start is accepted.
- mode_sel  input  2  player mode request.
- winner  input  1  counter WINNER flag (level).
- loser  input  1  counter LOSER flag (level).
- ctrl_value  output  2  drives the counter controlValue.
- init_value  output  WIDTH  drives the counter initialValue.
- init  output  1  counter INIT, one-cycle pulse per round.
- win_count  output  $clog2(WINS_TO_END+1)  wins this game.
- lose_count  output  $clog2(LOSSES_TO_END+1)  losses this game.
- round_num  output  8  current round, 1-based (0 before the first game).
- busy  output  1  high in LOAD, SETTLE, PLAY, ROUND_END.
- game_over  output  1  high in GAME_OVER.
- player_won  output  1  valid while game_over; 1 = wins threshold reached.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; seed register 0.
- States: IDLE, LOAD, SETTLE, PLAY, ROUND_END, GAME_OVER.
- IDLE → LOAD on start=1. Same edge: capture seed, clear tallies, round_num←1.
- LOAD (1 cycle):
  - init=1; init_value = seed_reg + (round_num−1), truncated to WIDTH (wraps modulo 2^WIDTH).
  - ctrl_value=0; timeout counter cleared. → SETTLE.
- SETTLE (1 cycle): init=0; winner/loser ignored, so stale flags from the previous round cannot end the new round. → PLAY.
- PLAY:
  - ctrl_value is a registered copy of mode_sel, updated every cycle, so a change appears one cycle later.
  - Timeout counter increments each cycle.
  - Exit checks, evaluated each cycle in priority order:
    - winner=1 → win.
    - else loser=1 → loss.
    - else the timeout counter reaches ROUND_TIMEOUT−1 → loss.
  - winner and loser both high counts as a win.
  - Win or loss → ROUND_END; the matching tally increments on that same edge, saturating at its threshold.
- ROUND_END (1 cycle):
  - ctrl_value held. init_value is held at the last loaded value throughout PLAY and ROUND_END.
  - win_count==WINS_TO_END → GAME_OVER, player_won=1.
  - else lose_count==LOSSES_TO_END → GAME_OVER, player_won=0.
  - else round_num increments (wraps at 255) → LOAD.
- GAME_OVER:
  - game_over=1; tallies, round_num and player_won held; ctrl_value=0.
  - start=1 → LOAD, with the same capture/clear actions as from IDLE; game_over and player_won clear on that edge.
- start is ignored in all states except IDLE and GAME_OVER.
- Reset mid-round: immediate return to IDLE with outputs 0; no pulse on init.
- Latency:
  - start to init pulse: 1 cycle.
  - A round resolved by winner/loser at the first PLAY cycle takes 4 cycles LOAD→LOAD.
  - Counter flags are sampled only in PLAY.

Test Plan:
- Reset mid-PLAY (rst low for 1 ns between clock edges) → all outputs 0 immediately, state IDLE; next start re-inits with round_num=1.
- Three-win game, defaults: seed=10, start pulse; drive winner=1 at PLAY entry each round.
  - init pulses carry init_value=10, 11, 12.
  - win_count=3, game_over=1, player_won=1.
  - round_num=3 at game end.
- Losses by flag and timeout, defaults: seed=2.
  - Round 1: loser=1 → loss.
  - Round 2: no flags → loss after exactly 32 PLAY cycles.
  - Round 3: loser=1 → loss.
  - Result: lose_count=3, player_won=0.
- Simultaneous and stale flags:
  - winner=loser=1 in PLAY → counted as a win.
  - winner held high through LOAD/SETTLE → not counted until PLAY.
- Mode passthrough and wrap:
  - mode_sel steps 0→1→2→3 during PLAY → ctrl_value follows each with 1-cycle delay.
  - seed=15, second round → init_value=0 (wrap).
- Restart from GAME_OVER: start=1 → game_over=0, tallies 0, round_num=1, init pulse next cycle. start pulses during PLAY have no effect.
